// File: rtl/mlp_pkg.sv
// Shared widths, fixed-point formats and FSM state type for the MLP datapath.
package mlp_pkg;

  localparam int NEURON_W    = 16;  // Q8.8 activation
  localparam int WEIGHT_W    = 8;   // Q1.7 weight
  localparam int ADDR_W      = 12;
  localparam int NEURON_FRAC = 8;
  localparam int WEIGHT_FRAC = 7;

  // Product of Q8.8 and Q1.7 is Q9.15.
  localparam int PROD_W = NEURON_W + WEIGHT_W;

  // Going from Q.15 back to Q.8 drops WEIGHT_FRAC fractional bits.
  localparam int NARROW_SHIFT = NEURON_FRAC + WEIGHT_FRAC - NEURON_FRAC;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sat_narrow.sv
// Narrows an accumulator value to a Q8.8 activation: arithmetic shift,
// signed saturation to 16 bits, then optional ReLU.
module sat_narrow
  import mlp_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0]    i_value,
  output logic        [NEURON_W-1:0] o_data,
  output logic                       o_sat
);

  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_fits;

  // Arithmetic shift truncates toward negative infinity.
  assign w_shifted = i_value >>> NARROW_SHIFT;

  // Value fits in NEURON_W signed bits when all bits above the sign bit match it.
  assign w_fits = (&w_shifted[ACC_W-1:NEURON_W-1]) | ~(|w_shifted[ACC_W-1:NEURON_W-1]);

  // Saturate on overflow, then clamp negatives when ReLU is enabled.
  always_comb begin
    o_data = w_shifted[NEURON_W-1:0];
    o_sat  = 1'b0;
    if (!w_fits) begin
      o_sat  = 1'b1;
      o_data = w_shifted[ACC_W-1] ? {1'b1, {(NEURON_W-1){1'b0}}}
                                  : {1'b0, {(NEURON_W-1){1'b1}}};
    end
    if (RELU_EN != 0 && o_data[NEURON_W-1]) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/mac_stage_3.sv
// Stage 3 of the MLP pipeline: multiply-accumulate of activation x weight,
// writeback of narrowed neuron results and layer-completion tracking.
module mac_stage_3
  import mlp_pkg::*;
#(
  parameter int RELU_EN = 1,
  parameter int ACC_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       done_3,
  input  logic signed [NEURON_W-1:0] neuron_val_3,
  input  logic signed [WEIGHT_W-1:0] weight_val_3,
  input  logic                       reset_mult_acc_3,
  input  logic        [ADDR_W-1:0]   out_neuron_addr_3,
  input  logic                       write_neuron_3,
  output logic                       wr_en,
  output logic        [ADDR_W-1:0]   wr_addr,
  output logic        [NEURON_W-1:0] wr_data,
  output logic                       layer_done,
  output logic                       sat_flag
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t r_state;
  state_t w_state_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_wr_en;
  logic        [ADDR_W-1:0] r_wr_addr;
  logic      [NEURON_W-1:0] r_wr_data;
  logic                     r_sat_flag;

  logic signed [PROD_W-1:0] w_product;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_sum_ovf;
  logic signed [ACC_W-1:0]  w_next_acc;
  logic                     w_acc_clamp;
  logic      [NEURON_W-1:0] w_narrow_data;
  logic                     w_narrow_sat;

  assign w_product  = PROD_W'(neuron_val_3) * PROD_W'(weight_val_3);
  assign w_prod_ext = ACC_W'(w_product);

  // One guard bit exposes overflow of the signed sum.
  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // Next accumulator value: restart on a new neuron, else saturating add.
  always_comb begin
    w_acc_clamp = 1'b0;
    w_next_acc  = w_sum[ACC_W-1:0];
    if (reset_mult_acc_3) begin
      w_next_acc = w_prod_ext;
    end else if (w_sum_ovf) begin
      w_acc_clamp = 1'b1;
      w_next_acc  = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Narrowing works on this cycle's next-acc so a single-term neuron
  // (restart and write together) writes its own product.
  sat_narrow #(
    .ACC_W  (ACC_W),
    .RELU_EN(RELU_EN)
  ) u_sat_narrow (
    .i_value(w_next_acc),
    .o_data (w_narrow_data),
    .o_sat  (w_narrow_sat)
  );

  // Layer FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Layer FSM next state; dropping run returns to IDLE from anywhere.
  always_comb begin
    w_state_next = r_state;
    if (!run) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = ACTIVE;
        ACTIVE:  if (done_3) w_state_next = DRAIN;
        DRAIN:   w_state_next = DONE;
        DONE:    w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Accumulator, writeback registers and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_sat_flag <= 1'b0;
    end else if (!run) begin
      r_acc      <= '0;
      r_wr_en    <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      r_acc   <= w_next_acc;
      r_wr_en <= write_neuron_3;
      if (write_neuron_3) begin
        r_wr_addr <= out_neuron_addr_3;
        r_wr_data <= w_narrow_data;
      end
      r_sat_flag <= r_sat_flag | w_acc_clamp | (write_neuron_3 & w_narrow_sat);
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign sat_flag   = r_sat_flag;
  assign layer_done = (r_state == DONE);

endmodule

// File: tb/tb_mac_stage_3.sv
// Directed + randomized bench for mac_stage_3, comparing a ReLU and a linear
// instance against an arithmetic reference model.
module tb_mac_stage_3;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset, run, done_3, reset_mult_acc_3, write_neuron_3;
  logic [15:0] neuron_val_3;
  logic [7:0]  weight_val_3;
  logic [11:0] out_neuron_addr_3;

  logic        wr_en_r, layer_done_r, sat_flag_r;
  logic [11:0] wr_addr_r;
  logic [15:0] wr_data_r;
  logic        wr_en_n, layer_done_n, sat_flag_n;
  logic [11:0] wr_addr_n;
  logic [15:0] wr_data_n;

  always #5 clk = ~clk;

  mac_stage_3 #(.RELU_EN(1), .ACC_W(32)) u_dut_relu (
    .clk(clk), .reset(reset), .run(run), .done_3(done_3),
    .neuron_val_3(neuron_val_3), .weight_val_3(weight_val_3),
    .reset_mult_acc_3(reset_mult_acc_3), .out_neuron_addr_3(out_neuron_addr_3),
    .write_neuron_3(write_neuron_3),
    .wr_en(wr_en_r), .wr_addr(wr_addr_r), .wr_data(wr_data_r),
    .layer_done(layer_done_r), .sat_flag(sat_flag_r)
  );

  mac_stage_3 #(.RELU_EN(0), .ACC_W(32)) u_dut_lin (
    .clk(clk), .reset(reset), .run(run), .done_3(done_3),
    .neuron_val_3(neuron_val_3), .weight_val_3(weight_val_3),
    .reset_mult_acc_3(reset_mult_acc_3), .out_neuron_addr_3(out_neuron_addr_3),
    .write_neuron_3(write_neuron_3),
    .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_data(wr_data_n),
    .layer_done(layer_done_n), .sat_flag(sat_flag_n)
  );

  // Reference model state
  longint      m_acc;
  bit          m_sat, m_wr_en, m_active;
  logic [11:0] m_addr;
  logic [15:0] m_data_r, m_data_n;
  int          m_since_done;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Q9.15 -> Q8.8 with floor rounding and 16-bit signed saturation.
  task automatic narrow(input longint v, output logic [15:0] relu, output logic [15:0] lin,
                        output bit sat);
    longint q;
    q   = (v >= 0) ? v / 128 : -((-v + 127) / 128);
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    lin  = q[15:0];
    relu = (q < 0) ? 16'h0000 : lin;
  endtask

  task automatic step(input bit r, input bit ru, input bit d, input bit rm, input bit wn,
                      input logic [15:0] n, input logic [7:0] w, input logic [11:0] a);
    longint      p, s;
    logic [15:0] dr, dn;
    bit          ns;
    reset = r; run = ru; done_3 = d; reset_mult_acc_3 = rm; write_neuron_3 = wn;
    neuron_val_3 = n; weight_val_3 = w; out_neuron_addr_3 = a;
    @(posedge clk);
    if (r) begin
      m_acc = 0; m_sat = 0; m_wr_en = 0; m_addr = '0; m_data_r = '0; m_data_n = '0;
      m_active = 0; m_since_done = -1;
    end else if (!ru) begin
      m_acc = 0; m_sat = 0; m_wr_en = 0; m_active = 0; m_since_done = -1;
    end else begin
      p = longint'($signed(n)) * longint'($signed(w));
      s = rm ? p : m_acc + p;
      if (s > AMAX) begin
        s = AMAX; m_sat = 1;
      end else if (s < AMIN) begin
        s = AMIN; m_sat = 1;
      end
      m_acc   = s;
      m_wr_en = wn;
      if (wn) begin
        narrow(s, dr, dn, ns);
        m_addr = a; m_data_r = dr; m_data_n = dn;
        if (ns) m_sat = 1;
      end
      if (m_since_done >= 0) m_since_done++;
      else if (m_active && d) m_since_done = 0;
      m_active = 1;
    end
    #1;
    chk("wr_en_relu",      32'(wr_en_r),      32'(m_wr_en));
    chk("wr_en_lin",       32'(wr_en_n),      32'(m_wr_en));
    chk("wr_addr_relu",    32'(wr_addr_r),    32'(m_addr));
    chk("wr_addr_lin",     32'(wr_addr_n),    32'(m_addr));
    chk("wr_data_relu",    32'(wr_data_r),    32'(m_data_r));
    chk("wr_data_lin",     32'(wr_data_n),    32'(m_data_n));
    chk("sat_flag_relu",   32'(sat_flag_r),   32'(m_sat));
    chk("sat_flag_lin",    32'(sat_flag_n),   32'(m_sat));
    chk("layer_done_relu", 32'(layer_done_r), 32'(m_since_done >= 1));
    chk("layer_done_lin",  32'(layer_done_n), 32'(m_since_done >= 1));
  endtask

  task automatic idle_run();
    step(0, 1, 0, 0, 0, 16'h0, 8'h0, 12'h0);
  endtask

  initial begin
    int          len;
    logic [11:0] ra;

    // Reset state
    step(1, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    step(1, 1, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    chk("reset_wr_en", 32'(wr_en_r), 32'h0);
    chk("reset_layer_done", 32'(layer_done_r), 32'h0);
    idle_run();

    // One-term neuron at address 5
    step(0, 1, 0, 1, 1, 16'h0100, 8'h40, 12'd5);
    chk("one_term_wr_en", 32'(wr_en_r), 32'h1);
    chk("one_term_wr_addr", 32'(wr_addr_r), 32'd5);
    chk("one_term_wr_data", 32'(wr_data_r), 32'h0080);
    idle_run();
    chk("one_term_wr_en_drop", 32'(wr_en_r), 32'h0);

    // Three-term neuron
    step(0, 1, 0, 1, 0, 16'h0200, 8'h40, 12'd7);
    step(0, 1, 0, 0, 0, 16'h0100, 8'h20, 12'd7);
    step(0, 1, 0, 0, 1, 16'hFF00, 8'h40, 12'd7);
    chk("three_term_wr_data", 32'(wr_data_r), 32'h00C0);

    // Negative single term: ReLU clamps, linear keeps it
    step(0, 1, 0, 1, 1, 16'hFF00, 8'h7F, 12'd2);
    chk("neg_relu_wr_data", 32'(wr_data_r), 32'h0000);
    chk("neg_lin_wr_data", 32'(wr_data_n), 32'hFF02);
    chk("neg_no_sat", 32'(sat_flag_r), 32'h0);

    // 200 large terms: narrowing saturates, flag sticky until run falls
    for (int t = 0; t < 200; t++)
      step(0, 1, 0, t == 0, t == 199, 16'h7FFF, 8'h7F, 12'd9);
    chk("big_wr_data", 32'(wr_data_r), 32'h7FFF);
    chk("big_sat", 32'(sat_flag_r), 32'h1);
    repeat (3) idle_run();
    chk("big_sat_sticky", 32'(sat_flag_r), 32'h1);
    step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    chk("big_sat_cleared", 32'(sat_flag_r), 32'h0);

    // Accumulator clamps at positive then negative bound
    idle_run();
    for (int t = 0; t < 600; t++)
      step(0, 1, 0, t == 0, t == 599, 16'h8000, 8'h80, 12'd10);
    chk("acc_pos_relu", 32'(wr_data_r), 32'h7FFF);
    chk("acc_pos_lin", 32'(wr_data_n), 32'h7FFF);
    step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    idle_run();
    for (int t = 0; t < 599; t++)
      step(0, 1, 0, t == 0, 0, 16'h8000, 8'h7F, 12'd11);
    chk("acc_neg_sat_before_write", 32'(sat_flag_r), 32'h1);
    step(0, 1, 0, 0, 1, 16'h8000, 8'h7F, 12'd11);
    chk("acc_neg_relu", 32'(wr_data_r), 32'h0000);
    chk("acc_neg_lin", 32'(wr_data_n), 32'h8000);
    step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);

    // Randomized neurons, including back-to-back single-term writes
    idle_run();
    for (int k = 0; k < 60; k++) begin
      len = $urandom_range(1, 6);
      ra  = 12'($urandom);
      for (int t = 0; t < len; t++)
        step(0, 1, 0, t == 0, t == len - 1, 16'($urandom), 8'($urandom), ra);
      if ($urandom_range(0, 3) == 0) idle_run();
      if ($urandom_range(0, 9) == 0) step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    end

    // Layer completion with a final write on the done cycle
    step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    idle_run();
    step(0, 1, 0, 1, 0, 16'h0300, 8'h20, 12'd3);
    step(0, 1, 1, 0, 1, 16'h0100, 8'h10, 12'd3);
    chk("done_wr_en", 32'(wr_en_r), 32'h1);
    chk("done_ld_early", 32'(layer_done_r), 32'h0);
    idle_run();
    chk("done_wr_en_drop", 32'(wr_en_r), 32'h0);
    chk("done_ld_rise", 32'(layer_done_r), 32'h1);
    repeat (3) idle_run();
    chk("done_ld_hold", 32'(layer_done_r), 32'h1);
    step(0, 0, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    chk("done_ld_clear", 32'(layer_done_r), 32'h0);
    step(0, 1, 1, 0, 0, 16'h0, 8'h0, 12'h0);
    idle_run();
    chk("done_ignored_in_idle", 32'(layer_done_r), 32'h0);

    // Reset after a write, and reset overriding a write
    step(0, 1, 0, 1, 1, 16'h0100, 8'h40, 12'd9);
    step(1, 1, 0, 0, 0, 16'h0, 8'h0, 12'h0);
    chk("rst_wr_en", 32'(wr_en_r), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr_r), 32'h0);
    chk("rst_wr_data", 32'(wr_data_r), 32'h0);
    chk("rst_sat", 32'(sat_flag_r), 32'h0);
    chk("rst_ld", 32'(layer_done_r), 32'h0);
    step(1, 1, 0, 1, 1, 16'h0100, 8'h40, 12'd4);
    chk("rst_overrides_write", 32'(wr_en_r), 32'h0);
    idle_run();
    chk("rst_no_late_write", 32'(wr_en_r), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_stage_3.md
MAC_STAGE_3 -- requirements
Module: mac_stage_3

Interface
REQ-001 The block SHALL declare parameter RELU_EN, default 1, meaning that when set to 1 negative results are clamped to 0 before writeback.
REQ-002 The block SHALL declare parameter ACC_W, default 32, meaning the signed accumulator width.
REQ-003 The block SHALL provide port clk, input, 1 bit, as the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit; reset SHALL be synchronous and active-high.
REQ-005 The block SHALL provide port run, input, 1 bit, as the layer-active enable.
REQ-006 The block SHALL provide the stage-3 inputs, all 1 bit unless stated: done_3 (last operand of layer), neuron_val_3 (16 bits, signed Q8.8 activation), weight_val_3 (8 bits, signed Q1.7 weight), reset_mult_acc_3 (first term of a new neuron), out_neuron_addr_3 (12 bits, destination address), write_neuron_3 (last term of the current neuron).
REQ-007 The block SHALL provide the outputs: wr_en (1 bit, neuron-memory write strobe), wr_addr (12 bits), wr_data (16 bits, signed Q8.8), layer_done (1 bit), sat_flag (1 bit, sticky saturation indicator).

Function
REQ-008 The block SHALL form product = neuron_val_3 * weight_val_3 as a 24-bit signed Q9.15 value, sign-extended to ACC_W.
REQ-009 With run=1 and reset_mult_acc_3=1, next acc SHALL be product; with reset_mult_acc_3=0, next acc SHALL be the saturating sum acc+product.
REQ-010 The accumulator sum SHALL clamp to the ACC_W signed bounds (0x7FFFFFFF / 0x80000000 at ACC_W=32) and SHALL set sat_flag on clamping.
REQ-011 When write_neuron_3=1 is sampled, the final value SHALL be this cycle's next-acc value, so that reset_mult_acc_3=1 together with write_neuron_3=1 writes a one-term neuron.
REQ-012 The final value SHALL be arithmetically shifted right 7 (truncation toward negative infinity), then saturated to 16-bit signed; any saturation SHALL set sat_flag.
REQ-013 If RELU_EN=1, negative narrowed results SHALL be written as 0x0000.
REQ-014 wr_en SHALL be 1 exactly one cycle after write_neuron_3 is sampled high with run=1, with wr_addr equal to the sampled out_neuron_addr_3 and wr_data the value from REQ-012/013; otherwise wr_en SHALL be 0.
REQ-015 Back-to-back write_neuron_3 pulses SHALL produce back-to-back wr_en pulses with no loss.
REQ-016 The FSM SHALL have states IDLE, ACTIVE, DRAIN and DONE.
REQ-017 FSM transitions: IDLE->ACTIVE on run=1; ACTIVE->DRAIN on done_3=1; DRAIN->DONE unconditionally after one cycle, so the final write has retired; DONE holds until run=0; any state ->IDLE on run=0.
REQ-018 layer_done SHALL be 1 only in state DONE.
REQ-019 With run=0, acc SHALL clear to 0, wr_en SHALL be 0 the next cycle, and sat_flag SHALL clear; the stage-3 inputs SHALL be ignored.
REQ-020 If done_3 and write_neuron_3 are sampled high together, the write SHALL be performed and layer_done SHALL rise two cycles later.
REQ-021 The stage-3 inputs SHALL be consumed every cycle with no backpressure.

Reset
REQ-022 When reset=1, the block SHALL on the next edge set: state=IDLE, acc=0, wr_en=0, wr_addr=0, wr_data=0, layer_done=0, sat_flag=0.
REQ-023 reset SHALL override run; reset asserted mid-layer SHALL drop any pending write.

Structure
REQ-024 Package mlp_pkg SHALL hold: NEURON_W=16, WEIGHT_W=8, ADDR_W=12, NEURON_FRAC=8, WEIGHT_FRAC=7, and the FSM state enum.
REQ-025 The narrowing shift, saturation and ReLU of REQ-012/013 SHALL be one combinational sub-module, sat_narrow.

Verification
REQ-026 Bench SHALL cover: one-term neuron 0x0100 * 0x40 with reset_mult_acc_3=1 and write_neuron_3=1 at addr 5 -> next cycle wr_en=1, wr_addr=5, wr_data=0x0080.
REQ-027 Bench SHALL cover: three terms 0x0200*0x40, 0x0100*0x20, 0xFF00*0x40 -> wr_data=0x00C0.
REQ-028 Bench SHALL cover: RELU_EN=1 with 0xFF00*0x7F single term -> wr_data=0x0000; RELU_EN=0 -> wr_data=0xFF02.
REQ-029 Bench SHALL cover: 200 terms of 0x7FFF*0x7F -> wr_data=0x7FFF and sat_flag=1 until run falls.
REQ-030 Bench SHALL cover: done_3 with a final write -> wr_en on cycle +1, layer_done on cycle +2 held until run=0, then the FSM in IDLE.
REQ-031 Bench SHALL cover: reset=1 asserted in the cycle after write_neuron_3 -> no wr_en and all outputs 0.
